data_memory_ls: RTL and testbench

Parametrised successor data memory for the RISC-V core. It is byte-addressable with byte, half and word loads and stores, and sign or zero extension on loads. Reads are registered with a valid strobe, and misaligned or illegal accesses are flagged. After reset, a hardware init sequencer clears the array. The block sits between the ALU result (address), the register file (store data) and the writeback mux.

---
 rtl/dmem_pkg.sv | 39 +++
 rtl/data_memory_ls_if.sv | 26 ++
 rtl/dmem_load_align.sv | 30 +++
 rtl/data_memory_ls.sv | 147 ++++++++++++++
 tb/tb_data_memory_ls.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the byte-addressable data memory and its load aligner.
`timescale 1ns/1ps
package dmem_pkg;

  localparam int DMEM_DATA_WIDTH = 32;
  localparam int BYTE_LANES      = DMEM_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    LS_BYTE = 2'b00,
    LS_HALF = 2'b01,
    LS_WORD = 2'b10,
    LS_RSVD = 2'b11
  } ls_type_e;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } dmem_state_e;

  function automatic logic is_aligned(input ls_type_e ls_type, input logic [1:0] offset);
    case (ls_type)
      LS_BYTE: is_aligned = 1'b1;
      LS_HALF: is_aligned = ~offset[0];
      LS_WORD: is_aligned = (offset == 2'b00);
      default: is_aligned = 1'b0;
    endcase
  endfunction

  // Lanes touched by a store; only meaningful for aligned accesses.
  function automatic logic [BYTE_LANES-1:0] lane_mask(input ls_type_e ls_type, input logic [1:0] offset);
    case (ls_type)
      LS_BYTE: lane_mask = 4'b0001 << offset;
      LS_HALF: lane_mask = 4'b0011 << offset;
      LS_WORD: lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_ls_if.sv
// Request/response bundle between the core datapath and the data memory.
`timescale 1ns/1ps
interface data_memory_ls_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  MEM_R;
  logic                  MEM_W;
  logic [1:0]            LS_TYPE;
  logic                  LS_UNSIGNED;
  logic [DATA_WIDTH-1:0] MEM_ADDRESS;
  logic [DATA_WIDTH-1:0] MEM_DATA_W;
  logic [DATA_WIDTH-1:0] MEM_DATA_R;
  logic                  MEM_RVALID;
  logic                  MEM_READY;
  logic                  MEM_ERR;

  modport master (
    output MEM_R, MEM_W, LS_TYPE, LS_UNSIGNED, MEM_ADDRESS, MEM_DATA_W,
    input  MEM_DATA_R, MEM_RVALID, MEM_READY, MEM_ERR
  );

  modport slave (
    input  MEM_R, MEM_W, LS_TYPE, LS_UNSIGNED, MEM_ADDRESS, MEM_DATA_W,
    output MEM_DATA_R, MEM_RVALID, MEM_READY, MEM_ERR
  );
endinterface

// File: rtl/dmem_load_align.sv
// Combinational lane extract and sign/zero extension of a 32-bit word.
`timescale 1ns/1ps
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [DMEM_DATA_WIDTH-1:0] word_i,
  input  logic [1:0]                 offset_i,
  input  ls_type_e                   ls_type_i,
  input  logic                       unsigned_i,
  output logic [DMEM_DATA_WIDTH-1:0] data_o
);

  logic [DMEM_DATA_WIDTH-1:0] shifted;
  logic [7:0]                 byte_sel;
  logic [15:0]                half_sel;

  always_comb begin
    shifted  = word_i >> {offset_i, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = offset_i[1] ? word_i[31:16] : word_i[15:0];
    data_o   = '0;
    case (ls_type_i)
      LS_BYTE: data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
      LS_HALF: data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
      LS_WORD: data_o = word_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/data_memory_ls.sv
// Byte-addressable data memory with registered loads, access checking and a
// post-reset clearing sequencer.
`timescale 1ns/1ps
module data_memory_ls
  import dmem_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEM_ADD_SIZE = 9,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
  input logic              CLK,
  input logic              RST,
  data_memory_ls_if.slave  bus
);

  localparam int         DEPTH  = 2 ** MEM_ADD_SIZE;
  localparam logic [0:0] S_INIT = INIT;
  localparam logic [0:0] S_RUN  = RUN;

  logic [0:0]              state_q, state_d;
  logic [MEM_ADD_SIZE-1:0] cnt_q, cnt_d;
  logic                    ready_q, ready_d;
  logic                    rvalid_q, rvalid_d;
  logic                    err_q, err_d;
  logic                    zero_q, zero_d;
  logic [1:0]              off_q, off_d;
  ls_type_e                type_q, type_d;
  logic                    uns_q, uns_d;

  ls_type_e                req_type;
  logic [1:0]              req_off;
  logic [MEM_ADD_SIZE-1:0] req_idx;
  logic                    run, req, legal, do_store, do_load, rsp;
  logic                    unused_addr;

  logic [BYTE_LANES-1:0]   wr_en;
  logic [MEM_ADD_SIZE-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic [DATA_WIDTH-1:0]   aligned;

  assign req_type    = ls_type_e'(bus.LS_TYPE);
  assign req_off     = bus.MEM_ADDRESS[1:0];
  assign req_idx     = bus.MEM_ADDRESS[MEM_ADD_SIZE+1:2];
  assign unused_addr = ^bus.MEM_ADDRESS[DATA_WIDTH-1:MEM_ADD_SIZE+2];

  assign run      = (state_q == S_RUN);
  assign req      = run & (bus.MEM_R | bus.MEM_W);
  assign legal    = is_aligned(req_type, req_off) & ~(bus.MEM_R & bus.MEM_W);
  assign do_store = req & legal & bus.MEM_W;
  assign do_load  = req & legal & bus.MEM_R;
  // Any read issued in RUN gets a response, legal or not.
  assign rsp      = run & bus.MEM_R;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    if (state_q == S_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (&cnt_q) begin
        state_d = S_RUN;
      end
    end
    ready_d  = (state_d == S_RUN);
    rvalid_d = rsp;
    err_d    = req & ~legal;
    zero_d   = rsp ? ~legal : zero_q;
    off_d    = do_load ? req_off : off_q;
    type_d   = do_load ? req_type : type_q;
    uns_d    = do_load ? bus.LS_UNSIGNED : uns_q;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_INIT;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      zero_q   <= 1'b1;
      off_q    <= 2'b00;
      type_q   <= LS_WORD;
      uns_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      zero_q   <= zero_d;
      off_q    <= off_d;
      type_q   <= type_d;
      uns_q    <= uns_d;
    end
  end

  // Init sequencer owns the write port until RUN; stores replicate data across lanes.
  always_comb begin
    wr_en   = '0;
    wr_addr = req_idx;
    wr_data = bus.MEM_DATA_W;
    if (state_q == S_INIT) begin
      wr_en   = '1;
      wr_addr = cnt_q;
      wr_data = INIT_VALUE;
    end else if (do_store) begin
      wr_en = lane_mask(req_type, req_off);
      case (req_type)
        LS_BYTE: wr_data = {BYTE_LANES{bus.MEM_DATA_W[7:0]}};
        LS_HALF: wr_data = {(BYTE_LANES/2){bus.MEM_DATA_W[15:0]}};
        default: wr_data = bus.MEM_DATA_W;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi < BYTE_LANES; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] rd_byte_q;

      always_ff @(posedge CLK) begin
        if (wr_en[gi]) begin
          mem[wr_addr] <= wr_data[8*gi +: 8];
        end
        if (do_load) begin
          rd_byte_q <= mem[req_idx];
        end
      end

      assign rd_word[8*gi +: 8] = rd_byte_q;
    end
  endgenerate

  dmem_load_align u_align (
    .word_i     (rd_word),
    .offset_i   (off_q),
    .ls_type_i  (type_q),
    .unsigned_i (uns_q),
    .data_o     (aligned)
  );

  assign bus.MEM_DATA_R = zero_q ? '0 : aligned;
  assign bus.MEM_RVALID = rvalid_q;
  assign bus.MEM_READY  = ready_q;
  assign bus.MEM_ERR    = err_q;

endmodule

// File: tb/tb_data_memory_ls.sv
// Self-checking bench for data_memory_ls: vector table plus reset/init sequences.
`timescale 1ns/1ps
module tb_data_memory_ls;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  data_memory_ls_if #(.DATA_WIDTH(32)) bus ();

  data_memory_ls #(
    .DATA_WIDTH   (32),
    .MEM_ADD_SIZE (9),
    .INIT_VALUE   (32'h0)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic        r;
    logic        w;
    logic [1:0]  t;
    logic        u;
    logic [31:0] a;
    logic [31:0] wd;
    logic        ev;
    logic [31:0] ed;
    logic        ee;
  } vec_t;

  typedef struct {
    logic        ev;
    logic [31:0] ed;
    logic        ee;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] hold     = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_bus(input logic r, input logic w, input logic [1:0] t, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
    bus.MEM_R       = r;
    bus.MEM_W       = w;
    bus.LS_TYPE     = t;
    bus.LS_UNSIGNED = u;
    bus.MEM_ADDRESS = a;
    bus.MEM_DATA_W  = wd;
  endtask

  // Drive at negedge, push expectation, let one edge sample it, check at next negedge.
  task automatic run_vec(input vec_t v, input string name);
    exp_t e;
    set_bus(v.r, v.w, v.t, v.u, v.a, v.wd);
    if (v.ev) hold = v.ed;
    e.ev = v.ev; e.ed = hold; e.ee = v.ee; e.name = name;
    sb_q.push_back(e);
    @(posedge CLK);
    @(negedge CLK);
    e = sb_q.pop_front();
    chk({e.name, "_rvalid"}, 32'(bus.MEM_RVALID), 32'(e.ev));
    chk({e.name, "_err"},    32'(bus.MEM_ERR),    32'(e.ee));
    chk({e.name, "_data"},   bus.MEM_DATA_R,      e.ed);
    $display("%s r=%0b w=%0b t=%0d u=%0b a=%h wd=%h -> rv=%0b err=%0b data=%h",
             e.name, v.r, v.w, v.t, v.u, v.a, v.wd, bus.MEM_RVALID, bus.MEM_ERR, bus.MEM_DATA_R);
  endtask

  // Hold reset 3 cycles, then count cycles until READY; requests during init must be ignored.
  task automatic reset_and_init(input string tag);
    int cycles;
    @(negedge CLK);
    RST = 1'b1;
    set_bus(1'b1, 1'b1, 2'b11, 1'b0, 32'h10, 32'hFFFF_FFFF);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk({tag, "_rst_ready"},  32'(bus.MEM_READY),  32'd0);
    chk({tag, "_rst_rvalid"}, 32'(bus.MEM_RVALID), 32'd0);
    chk({tag, "_rst_err"},    32'(bus.MEM_ERR),    32'd0);
    chk({tag, "_rst_data"},   bus.MEM_DATA_R,      32'h0);
    RST = 1'b0;
    cycles = 0;
    while (cycles < 2000) begin
      if (cycles[0]) set_bus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
      else           set_bus(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hFFFF_FFFF);
      @(posedge CLK);
      cycles++;
      @(negedge CLK);
      if (bus.MEM_RVALID !== 1'b0 || bus.MEM_ERR !== 1'b0) begin
        chk({tag, "_init_quiet"}, {30'd0, bus.MEM_RVALID, bus.MEM_ERR}, 32'd0);
      end
      if (bus.MEM_READY === 1'b1) break;
    end
    chk({tag, "_init_cycles"}, 32'(cycles), 32'd512);
    set_bus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
    hold = 32'h0;
    $display("%s init done after %0d cycles", tag, cycles);
  endtask

  vec_t vecs[$];

  initial begin
    vec_t v;
    set_bus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

    //          r     w     t      u     addr          wdata         ev    exp           ee
    vecs.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0,        1'b1, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEADBEEF, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1'b1, 32'hDEADBEEF,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0011, 32'h0,        1'b1, 32'hFFFFFFBE,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0011, 32'h0,        1'b1, 32'h000000BE,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0012, 32'h0,        1'b1, 32'hFFFFDEAD,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0,        1'b1, 32'h0000DEAD,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'hAAAAAA55, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1'b1, 32'h55ADBEEF,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0011, 32'h0,        1'b1, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h11223344, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0022, 32'hCAFEF00D, 1'b0, 32'h0,         1'b1});
    vecs.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,        1'b1, 32'h11223344,  1'b0});
    vecs.push_back('{1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h0,        1'b1, 32'h0,         1'b1});
    vecs.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,        1'b1, 32'h11223344,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0020, 32'h0,        1'b1, 32'h0,         1'b1});
    vecs.push_back('{1'b0, 1'b1, 2'b11, 1'b0, 32'h0000_0020, 32'h99999999, 1'b0, 32'h0,         1'b1});
    vecs.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,        1'b1, 32'h11223344,  1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,        1'b0, 32'h0,         1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0810, 32'h0BADF00D, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        1'b1, 32'h0BADF00D,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'b00, 1'b1, 32'hFFFF_F813, 32'h0,        1'b1, 32'h0000000B,  1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0016, 32'hFFFF8001, 1'b0, 32'h0,         1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_0016, 32'h0,        1'b1, 32'hFFFF8001,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0017, 32'h0,        1'b1, 32'hFFFFFF80,  1'b0});
    vecs.push_back('{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0,        1'b1, 32'h80010000,  1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0014, 32'h0,        1'b0, 32'h0,         1'b0});

    reset_and_init("boot");
    chk("boot_ready", 32'(bus.MEM_READY), 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_ready", i), 32'(bus.MEM_READY), 32'd1);
    end

    // Reset arriving during a read cycle: the response must be dropped.
    @(negedge CLK);
    set_bus(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    #2 RST = 1'b1;
    @(negedge CLK);
    chk("midrst_rvalid", 32'(bus.MEM_RVALID), 32'd0);
    chk("midrst_ready",  32'(bus.MEM_READY),  32'd0);
    chk("midrst_data",   bus.MEM_DATA_R,      32'h0);
    reset_and_init("rerun");

    v = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 1'b1, 32'h0, 1'b0};
    run_vec(v, "post_rst_rd10");
    v = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0, 1'b1, 32'h0, 1'b0};
    run_vec(v, "post_rst_rd14");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
